// File: rtl/pipe_skid_reg.sv
// Elastic two-entry pipeline register (main + skid) with registered in_ready.
// Consumer back-pressure is absorbed by the skid entry so in_ready never sees out_ready combinationally.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State, flags and both entries update together; out_data is always the main entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= BUSY;
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        out_data <= in_data;
                    end else if (in_fire) begin
                        state     <= FULL;
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state    <= BUSY;
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, then randomized traffic against a queue model.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Held entries must not move while the consumer stalls.
    property p_stall_stable;
        @(posedge clk) disable iff (rst)
            (out_valid && !out_ready && !flush) |=> ($stable(out_data) && out_valid);
    endproperty
    a_stall_stable: assert property (p_stall_stable)
        else begin
            errors++;
            $display("FAIL stall_stable: out_data=%h out_valid=%b changed during stall", out_data, out_valid);
        end

    // Reference: a FIFO of at most two entries; occupancy alone defines the flags.
    logic [31:0] q[$];
    bit          data_zero;

    function automatic void model_update(input logic r, input logic f, input logic iv,
                                         input logic [31:0] d, input logic ordy);
        bit can_take = (q.size() < 2);
        bit has_head = (q.size() > 0);
        if (r) begin
            q.delete();
            data_zero = 1'b1;
        end else if (f) begin
            q.delete();
        end else begin
            if (has_head && ordy) void'(q.pop_front());
            if (iv && can_take) begin
                q.push_back(d);
                data_zero = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        model_update(r, f, iv, d, ordy);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ev;
        logic        er;
        logic        cd;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic ev, input logic er,
                                input logic cd, input logic [31:0] ed);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.er = er; v.cd = cd; v.ed = ed;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        data_zero = 1'b1;

        //  r  f  iv data            ordy ev er cd expected data
        // reset held two cycles with live input
        add(1, 0, 1, 32'hDEAD_BEEF, 0,  0, 1, 1, 32'h0);
        add(1, 0, 1, 32'hDEAD_BEEF, 0,  0, 1, 1, 32'h0);
        add(0, 0, 0, 32'h0,         0,  0, 1, 1, 32'h0);
        // streaming at full rate
        add(0, 0, 1, 32'h1,         1,  1, 1, 1, 32'h1);
        add(0, 0, 1, 32'h2,         1,  1, 1, 1, 32'h2);
        add(0, 0, 1, 32'h3,         1,  1, 1, 1, 32'h3);
        add(0, 0, 1, 32'h4,         1,  1, 1, 1, 32'h4);
        add(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0);
        // back-pressure fills the skid, then drains in order
        add(0, 0, 1, 32'hA,         0,  1, 1, 1, 32'hA);
        add(0, 0, 1, 32'hB,         0,  1, 0, 1, 32'hA);
        add(0, 0, 1, 32'h99,        0,  1, 0, 1, 32'hA);
        add(0, 0, 0, 32'h0,         1,  1, 1, 1, 32'hB);
        add(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0);
        // flush while full with a simultaneous push of C
        add(0, 0, 1, 32'hA,         0,  1, 1, 1, 32'hA);
        add(0, 0, 1, 32'hB,         0,  1, 0, 1, 32'hA);
        add(0, 1, 1, 32'hC,         0,  0, 1, 0, 32'h0);
        add(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0);
        add(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0);
        // flush from busy with a simultaneous pop
        add(0, 0, 1, 32'h5,         0,  1, 1, 1, 32'h5);
        add(0, 1, 0, 32'h0,         1,  0, 1, 0, 32'h0);
        // reset while full and consumer ready
        add(0, 0, 1, 32'h7,         0,  1, 1, 1, 32'h7);
        add(0, 0, 1, 32'h8,         0,  1, 0, 1, 32'h7);
        add(1, 0, 0, 32'h0,         1,  0, 1, 1, 32'h0);
        add(0, 0, 0, 32'h0,         1,  0, 1, 1, 32'h0);
        add(0, 0, 0, 32'h0,         1,  0, 1, 1, 32'h0);
        // refill after reset still has 1-cycle latency
        add(0, 0, 1, 32'h1234_5678, 0,  1, 1, 1, 32'h1234_5678);
        add(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0);

        #2;
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].er));
            if (vecs[i].cd) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
        end

        // randomized traffic against the queue model
        step(1, 0, 0, 32'h0, 0);
        for (int n = 0; n < 1000; n++) begin
            logic        r_r  = ($urandom_range(0, 199) == 0);
            logic        r_f  = ($urandom_range(0, 31) == 0);
            logic        r_iv = ($urandom_range(0, 9) < 7);
            logic        r_or = ($urandom_range(0, 1) == 1);
            logic [31:0] r_d  = r_iv ? $urandom : 32'h0;
            step(r_r, r_f, r_iv, r_d, r_or);
            chk($sformatf("rnd%0d_out_valid", n), 32'(out_valid), 32'(q.size() > 0));
            chk($sformatf("rnd%0d_in_ready", n), 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0)
                chk($sformatf("rnd%0d_out_data", n), out_data, q[0]);
            else if (data_zero)
                chk($sformatf("rnd%0d_out_data_zero", n), out_data, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
